minmax_stream: RTL and testbench

- Streaming, pipelined min/max reduction engine. Each beat carries NI lanes of W-bit data; a frame of one or more beats, ended by s_last, reduces to one value and its global index.
- Next generation of the combinational min/max tree. Adds a registered tree, valid/ready handshake, multi-beat frame accumulation, per-frame mode latching and index-overflow detection.
- Sits between sample producers (e.g. correlator or distance units) and decision logic.

---
 rtl/minmax_pkg.sv | 55 +++++
 rtl/minmax_stream_if.sv | 35 +++
 rtl/minmax_level.sv | 73 +++++++
 rtl/minmax_stream.sv | 188 ++++++++++++++++++
 tb/tb_minmax_stream.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/minmax_pkg.sv
// +----------------------------------------------------------------------------+
// | minmax_pkg -- shared constants, sideband type and compare helpers.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package minmax_pkg;

  localparam int MM_BOTH = 0;
  localparam int MM_MIN  = 1;
  localparam int MM_MAX  = 2;

  localparam int US_BOTH = 0;
  localparam int US_UNS  = 1;
  localparam int US_SGN  = 2;

  localparam int MAXW = 32;

  typedef struct packed {
    logic last;
    logic sgn;
    logic max;
  } side_t;

  function automatic int level_size(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = (r + 1) / 2;
    return r;
  endfunction

  // Operands are w-bit values zero-extended to MAXW; left-aligning them makes
  // a single MAXW-bit compare valid for both signed and unsigned modes.
  function automatic logic better(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                  input int w, input logic signed_mode,
                                  input logic max_mode);
    logic [MAXW-1:0] as_v;
    logic [MAXW-1:0] bs_v;
    logic lt;
    logic gt;
    as_v = a << (MAXW - w);
    bs_v = b << (MAXW - w);
    if (signed_mode) begin
      lt = $signed(as_v) < $signed(bs_v);
      gt = $signed(as_v) > $signed(bs_v);
    end else begin
      lt = as_v < bs_v;
      gt = as_v > bs_v;
    end
    return max_mode ? gt : lt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/minmax_stream_if.sv
// +----------------------------------------------------------------------------+
// | minmax_stream_if -- input beat stream and frame result handshake bundle.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface minmax_stream_if #(
  parameter int W    = 8,
  parameter int NI   = 8,
  parameter int IDXW = 7
);
  logic            s_valid;
  logic            s_ready;
  logic [NI*W-1:0] s_data;
  logic            s_last;
  logic            us_sel;
  logic            min_max_sel;
  logic            m_valid;
  logic            m_ready;
  logic [W-1:0]    m_result;
  logic [IDXW-1:0] m_index;
  logic            m_ovf;

  modport master (
    output s_valid, s_data, s_last, us_sel, min_max_sel, m_ready,
    input  s_ready, m_valid, m_result, m_index, m_ovf
  );

  modport slave (
    input  s_valid, s_data, s_last, us_sel, min_max_sel, m_ready,
    output s_ready, m_valid, m_result, m_index, m_ovf
  );
endinterface

`default_nettype wire

// File: rtl/minmax_level.sv
// +----------------------------------------------------------------------------+
// | minmax_level -- one pairwise compare level of the reduction tree.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module minmax_level
  import minmax_pkg::*;
#(
  parameter int W     = 8,
  parameter int LIW   = 3,
  parameter int N_IN  = 8,
  parameter int PIPE  = 1,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               en,
  input  wire logic               in_valid,
  input  wire logic [N_IN*W-1:0]  in_data,
  input  wire logic [N_IN*LIW-1:0] in_idx,
  input  wire side_t              in_side,
  output logic                    out_valid,
  output logic [N_OUT*W-1:0]      out_data,
  output logic [N_OUT*LIW-1:0]    out_idx,
  output side_t                   out_side
);

  logic [N_OUT*W-1:0]   c_data;
  logic [N_OUT*LIW-1:0] c_idx;

  // Lower lane is x; y only wins on a strict improvement.
  for (genvar j = 0; j < N_IN / 2; j++) begin : g_pair
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         take_y;
    assign x      = in_data[2*j*W +: W];
    assign y      = in_data[(2*j+1)*W +: W];
    assign take_y = better(MAXW'(y), MAXW'(x), W, in_side.sgn, in_side.max);
    assign c_data[j*W +: W]     = take_y ? y : x;
    assign c_idx[j*LIW +: LIW]  = take_y ? in_idx[(2*j+1)*LIW +: LIW]
                                         : in_idx[2*j*LIW +: LIW];
  end

  if (N_IN % 2 == 1) begin : g_odd
    assign c_data[(N_OUT-1)*W +: W]    = in_data[(N_IN-1)*W +: W];
    assign c_idx[(N_OUT-1)*LIW +: LIW] = in_idx[(N_IN-1)*LIW +: LIW];
  end

  if (PIPE != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_idx   <= '0;
        out_side  <= '0;
      end else if (en) begin
        out_valid <= in_valid;
        out_data  <= c_data;
        out_idx   <= c_idx;
        out_side  <= in_side;
      end
    end
  end else begin : g_comb
    assign out_valid = in_valid;
    assign out_data  = c_data;
    assign out_idx   = c_idx;
    assign out_side  = in_side;
  end

endmodule

`default_nettype wire

// File: rtl/minmax_stream.sv
// +----------------------------------------------------------------------------+
// | minmax_stream -- pipelined multi-beat min/max reduction with global index. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module minmax_stream
  import minmax_pkg::*;
#(
  parameter int W      = 8,
  parameter int NI     = 8,
  parameter int MAXB   = 16,
  parameter int IDXW   = (NI * MAXB > 1) ? $clog2(NI * MAXB) : 1,
  parameter int PIPE   = 1,
  parameter int MM_CFG = 0,
  parameter int US_CFG = 0
) (
  input wire logic        clk,
  input wire logic        rst,
  minmax_stream_if.slave  bus
);

  localparam int L   = $clog2(NI);
  localparam int LIW = (NI > 1) ? $clog2(NI) : 1;
  localparam int CW  = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int DW  = NI * W;
  localparam int IW  = NI * LIW;

  logic stall;
  logic adv;
  logic accept;

  assign stall       = bus.m_valid && !bus.m_ready;
  assign adv         = !stall;
  assign bus.s_ready = adv;
  assign accept      = bus.s_valid && adv;

  // Mode is captured on the first beat of a frame and rides with every beat.
  logic eff_sgn;
  logic eff_max;
  logic in_frame;
  logic lat_sgn;
  logic lat_max;

  assign eff_sgn = (US_CFG == US_UNS) ? 1'b0 : (US_CFG == US_SGN) ? 1'b1 : bus.us_sel;
  assign eff_max = (MM_CFG == MM_MIN) ? 1'b0 : (MM_CFG == MM_MAX) ? 1'b1 : bus.min_max_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame <= 1'b0;
      lat_sgn  <= 1'b0;
      lat_max  <= 1'b0;
    end else if (accept) begin
      if (!in_frame) begin
        lat_sgn <= eff_sgn;
        lat_max <= eff_max;
      end
      in_frame <= !bus.s_last;
    end
  end

  logic [L:0]         st_valid;
  logic [L:0][DW-1:0] st_data;
  logic [L:0][IW-1:0] st_idx;
  side_t [L:0]        st_side;

  assign st_valid[0] = accept;
  assign st_data[0]  = bus.s_data;
  assign st_side[0]  = {bus.s_last, in_frame ? lat_sgn : eff_sgn, in_frame ? lat_max : eff_max};

  for (genvar k = 0; k < NI; k++) begin : g_lane
    assign st_idx[0][k*LIW +: LIW] = LIW'(k);
  end

  for (genvar i = 0; i < L; i++) begin : g_level
    localparam int NIN  = level_size(NI, i);
    localparam int NOUT = level_size(NI, i + 1);
    logic [NOUT*W-1:0]   lv_data;
    logic [NOUT*LIW-1:0] lv_idx;

    minmax_level #(
      .W    (W),
      .LIW  (LIW),
      .N_IN (NIN),
      .PIPE (PIPE)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (st_valid[i]),
      .in_data   (st_data[i][NIN*W-1:0]),
      .in_idx    (st_idx[i][NIN*LIW-1:0]),
      .in_side   (st_side[i]),
      .out_valid (st_valid[i+1]),
      .out_data  (lv_data),
      .out_idx   (lv_idx),
      .out_side  (st_side[i+1])
    );

    assign st_data[i+1] = DW'(lv_data);
    assign st_idx[i+1]  = IW'(lv_idx);
  end

  logic [W-1:0]    beat_val;
  logic [LIW-1:0]  beat_lidx;
  side_t           beat_side;
  logic            beat_v;
  logic            acc_in_frame;
  logic            cnt_full;
  logic            acc_ovf;
  logic [CW-1:0]   beat_cnt;
  logic [W-1:0]    acc_value;
  logic [IDXW-1:0] acc_index;
  logic            beat_ovf;
  logic            take;
  logic [IDXW-1:0] gidx;
  logic [W-1:0]    nxt_value;
  logic [IDXW-1:0] nxt_index;

  assign beat_val  = st_data[L][W-1:0];
  assign beat_lidx = st_idx[L][LIW-1:0];
  assign beat_side = st_side[L];
  assign beat_v    = st_valid[L] && adv;

  always_comb begin
    beat_ovf  = acc_ovf || cnt_full;
    gidx      = IDXW'(int'(beat_cnt) * NI + int'(beat_lidx));
    take      = !acc_in_frame ||
                better(MAXW'(beat_val), MAXW'(acc_value), W, beat_side.sgn, beat_side.max);
    nxt_value = take ? beat_val : acc_value;
    nxt_index = take ? gidx : acc_index;
  end

  // cnt_full marks that beat MAXB-1 has been consumed; any later beat overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_in_frame <= 1'b0;
      cnt_full     <= 1'b0;
      acc_ovf      <= 1'b0;
      beat_cnt     <= '0;
      acc_value    <= '0;
      acc_index    <= '0;
    end else if (beat_v) begin
      acc_value <= nxt_value;
      acc_index <= nxt_index;
      if (beat_side.last) begin
        acc_in_frame <= 1'b0;
        cnt_full     <= 1'b0;
        acc_ovf      <= 1'b0;
        beat_cnt     <= '0;
      end else begin
        acc_in_frame <= 1'b1;
        acc_ovf      <= beat_ovf;
        if (beat_cnt == CW'(MAXB - 1)) cnt_full <= 1'b1;
        else                           beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  logic            out_valid;
  logic [W-1:0]    out_result;
  logic [IDXW-1:0] out_index;
  logic            out_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_index  <= '0;
      out_ovf    <= 1'b0;
    end else if (beat_v && beat_side.last) begin
      out_valid  <= 1'b1;
      out_result <= nxt_value;
      out_index  <= nxt_index;
      out_ovf    <= beat_ovf;
    end else if (bus.m_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.m_valid  = out_valid;
  assign bus.m_result = out_result;
  assign bus.m_index  = out_index;
  assign bus.m_ovf    = out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_minmax_stream.sv
// +----------------------------------------------------------------------------+
// | tb_minmax_stream -- directed scoreboard bench for minmax_stream.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_minmax_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  minmax_stream_if #(.W(5), .NI(4), .IDXW(4)) bus ();

  minmax_stream #(
    .W(5), .NI(4), .MAXB(4), .IDXW(4), .PIPE(1), .MM_CFG(0), .US_CFG(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [4:0] res;
    logic [3:0] idx;
    logic       ovf;
    logic       chk_idx;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [19:0] lanes(input int a, input int b, input int c, input int d);
    logic [4:0] la, lb, lc, ld;
    la = a[4:0];
    lb = b[4:0];
    lc = c[4:0];
    ld = d[4:0];
    return {ld, lc, lb, la};
  endfunction

  task automatic push(input int res, input int idx, input logic ovf, input logic chk_idx);
    exp_t x;
    x.res     = res[4:0];
    x.idx     = idx[3:0];
    x.ovf     = ovf;
    x.chk_idx = chk_idx;
    sbq.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send(input logic [19:0] d, input logic last, input logic us, input logic mm);
    logic ok;
    ok              = 1'b0;
    bus.s_valid     = 1'b1;
    bus.s_data      = d;
    bus.s_last      = last;
    bus.us_sel      = us;
    bus.min_max_sel = mm;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result actual=%0d/%0d required=none",
                 bus.m_result, bus.m_index);
      end else begin
        e = sbq.pop_front();
        if (bus.m_result !== e.res || bus.m_ovf !== e.ovf ||
            (e.chk_idx && bus.m_index !== e.idx)) begin
          failures++;
          $display("FAIL result actual=res%0d idx%0d ovf%0d required=res%0d idx%0d ovf%0d",
                   bus.m_result, bus.m_index, bus.m_ovf, e.res, e.idx, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.s_last      = 1'b0;
    bus.us_sel      = 1'b0;
    bus.min_max_sel = 1'b0;
    bus.m_ready     = 1'b1;
    rst             = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_m_valid", int'(bus.m_valid), 0);
    chk("reset_m_result", int'(bus.m_result), 0);
    chk("reset_m_index", int'(bus.m_index), 0);
    chk("reset_m_ovf", int'(bus.m_ovf), 0);
    chk("reset_s_ready", int'(bus.s_ready), 1);
    @(posedge clk);
    #1;

    // Single beat, unsigned min with a tie between lanes 1 and 3.
    push(3, 1, 1'b0, 1'b1);
    send(lanes(7, 3, 9, 3), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_c1", int'(bus.m_valid), 0);
    @(negedge clk);
    chk("latency_c2", int'(bus.m_valid), 0);
    @(negedge clk);
    chk("latency_c3", int'(bus.m_valid), 1);
    idle(5);

    // Signed max over three beats; beat 2 lane 0 ties beat 1 lane 1.
    push(15, 5, 1'b0, 1'b1);
    send(lanes(1, 2, 3, 4), 1'b0, 1'b1, 1'b1);
    send(lanes(-5, 15, 0, 0), 1'b0, 1'b1, 1'b1);
    send(lanes(15, 1, 1, 1), 1'b1, 1'b1, 1'b1);
    idle(6);

    // Back-to-back single-beat frames: signed then unsigned min of the same lanes.
    push(24, 2, 1'b0, 1'b1);
    send(lanes(-1, 3, -8, 2), 1'b1, 1'b1, 1'b0);
    push(2, 3, 1'b0, 1'b1);
    send(lanes(-1, 3, -8, 2), 1'b1, 1'b0, 1'b0);
    idle(6);

    // Backpressure across two single-beat frames.
    bus.m_ready = 1'b0;
    push(4, 3, 1'b0, 1'b1);
    send(lanes(1, 2, 3, 4), 1'b1, 1'b0, 1'b1);
    push(0, 2, 1'b0, 1'b1);
    send(lanes(9, 9, 0, 1), 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("bp_s_ready", int'(bus.s_ready), 0);
    chk("bp_m_valid", int'(bus.m_valid), 1);
    chk("bp_hold_result", int'(bus.m_result), 4);
    chk("bp_hold_index", int'(bus.m_index), 3);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    idle(6);

    // Mode toggles to max on beat 2; the frame must still reduce as min.
    push(2, 4, 1'b0, 1'b1);
    send(lanes(10, 6, 8, 12), 1'b0, 1'b0, 1'b0);
    send(lanes(2, 20, 20, 20), 1'b1, 1'b0, 1'b1);
    idle(6);

    // Five-beat frame overflows MAXB=4; the following frame is clean.
    push(9, 0, 1'b1, 1'b0);
    send(lanes(9, 20, 20, 20), 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) send(lanes(20, 20, 20, 20), 1'b0, 1'b0, 1'b0);
    send(lanes(20, 20, 20, 20), 1'b1, 1'b0, 1'b0);
    push(1, 2, 1'b0, 1'b1);
    send(lanes(5, 6, 1, 7), 1'b1, 1'b0, 1'b0);
    idle(6);

    // Reset in the middle of a max frame, then a fresh min frame.
    send(lanes(1, 1, 1, 1), 1'b0, 1'b0, 1'b1);
    send(lanes(1, 1, 1, 1), 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", int'(bus.m_valid), 0);
    chk("midrst_s_ready", int'(bus.s_ready), 1);
    @(posedge clk);
    #1;
    push(2, 3, 1'b0, 1'b1);
    send(lanes(4, 4, 4, 2), 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(posedge clk);
    idle(4);
    chk("drain_queue", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
